// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, datapath width and divider state encoding
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_DIVU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divu_state_t;

endpackage

// File: rtl/divu_unit_if.sv
// rtl/divu_unit_if.sv - EX-stage request and LO/HI result bundle of the divider
interface divu_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       alu_op;
    logic             op_valid;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output alu_op, op_valid, flush, dividend, divisor,
        input  busy, done, div_by_zero, lo, hi
    );

    modport slave (
        input  alu_op, op_valid, flush, dividend, divisor,
        output busy, done, div_by_zero, lo, hi
    );
endinterface

// File: rtl/divu_step.sv
// rtl/divu_step.sv - one radix-2 restoring division iteration (combinational)
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;

    assign r_sh = {r, q[WIDTH-1]};
    assign diff = r_sh - {1'b0, d};

    // No borrow out of the WIDTH+1-bit subtract means r_sh >= d.
    always_comb begin
        q_next = {q[WIDTH-2:0], 1'b0};
        r_next = r_sh[WIDTH-1:0];
        if (!diff[WIDTH]) begin
            r_next    = diff[WIDTH-1:0];
            q_next[0] = 1'b1;
        end
    end
endmodule

// File: rtl/divu_unit.sv
// rtl/divu_unit.sv - multi-cycle unsigned divider: FSM, iteration counter, operand and LO/HI registers
module divu_unit
    import alu_pkg::*;
#(
    parameter int         WIDTH   = alu_pkg::WIDTH,
    parameter logic [3:0] DIVU_OP = ALU_DIVU,
    parameter int         CNT_W   = $clog2(WIDTH)
) (
    input logic        clk,
    input logic        reset,
    divu_unit_if.slave bus
);
    divu_state_t      state;
    divu_state_t      state_n;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] hi_reg;
    logic             dbz_reg;
    logic             start;
    logic             last_iter;

    assign start     = bus.op_valid && (bus.alu_op == DIVU_OP) && !bus.flush;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    divu_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_n),
        .q_next (q_n)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_n = (bus.divisor != '0) ? RUN : DONE;
                else       state_n = IDLE;
            end
            RUN: begin
                if (bus.flush)     state_n = IDLE;
                else if (last_iter) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A zero divisor bypasses RUN and writes the saturated result immediately.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            d_reg   <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            lo_reg  <= '0;
            hi_reg  <= '0;
            dbz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (bus.divisor != '0) begin
                            d_reg <= bus.divisor;
                            q_reg <= bus.dividend;
                            r_reg <= '0;
                            count <= '0;
                        end else begin
                            lo_reg  <= '1;
                            hi_reg  <= bus.dividend;
                            dbz_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        q_reg <= q_n;
                        r_reg <= r_n;
                        count <= count + CNT_W'(1);
                        if (last_iter) begin
                            lo_reg  <= q_n;
                            hi_reg  <= r_n;
                            dbz_reg <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.lo          = lo_reg;
    assign bus.hi          = hi_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_divu_unit.sv
// tb/tb_divu_unit.sv - directed vector table and corner-case sequences for divu_unit
module tb_divu_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    divu_unit_if #(.WIDTH(32)) bus ();

    divu_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          busy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the launch edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.alu_op   = ALU_DIVU;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int  bc;
        bit  seen;
        bit  any_done;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0, 32};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0, 32};
        vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,    1'b0, 32};
        vecs[3] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1, 0};
        vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0, 32};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0, 32};
        vecs[6] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,    1'b0, 32};
        vecs[7] = '{32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,    1'b0, 32};

        reset        = 1'b0;
        bus.op_valid = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.flush    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(bc, seen);
            check($sformatf("v%0d_done_seen", i), 32'(seen), 32'd1);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].busy));
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
        end

        // Flush at the 10th RUN cycle: back to IDLE, results kept, no done.
        launch(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_after", 32'(bus.busy), 32'd0);
        check("flush_lo_kept", bus.lo, 32'h0FFF_FFFF);
        check("flush_hi_kept", bus.hi, 32'hF);
        any_done = 1'b0;
        repeat (35) begin
            if (bus.done) any_done = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", 32'(any_done), 32'd0);

        // Flush in IDLE blocks a start.
        bus.flush    = 1'b1;
        bus.op_valid = 1'b1;
        bus.alu_op   = ALU_DIVU;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_busy", 32'(bus.busy), 32'd0);
        check("flush_idle_done", 32'(bus.done), 32'd0);

        // Non-DIVU opcode must not launch.
        bus.op_valid = 1'b1;
        bus.alu_op   = ALU_SLL;
        repeat (2) @(negedge clk);
        bus.op_valid = 1'b0;
        check("sll_busy", 32'(bus.busy), 32'd0);
        check("sll_done", 32'(bus.done), 32'd0);
        check("sll_lo_kept", bus.lo, 32'h0FFF_FFFF);

        // Operands change after launch.
        launch(32'd1000, 32'd10);
        bus.dividend = 32'd5;
        bus.divisor  = 32'd0;
        wait_done(bc, seen);
        check("opchg_done_seen", 32'(seen), 32'd1);
        check("opchg_lo", bus.lo, 32'd100);
        check("opchg_hi", bus.hi, 32'd0);
        @(negedge clk);

        // Back-to-back: relaunch during the DONE cycle.
        launch(32'd100, 32'd7);
        wait_done(bc, seen);
        check("b2b_first_seen", 32'(seen), 32'd1);
        check("b2b_first_lo", bus.lo, 32'd14);
        launch(32'd50, 32'd6);
        check("b2b_second_busy", 32'(bus.busy), 32'd1);
        check("b2b_lo_hold", bus.lo, 32'd14);
        wait_done(bc, seen);
        check("b2b_second_seen", 32'(seen), 32'd1);
        check("b2b_second_busy_cycles", 32'(bc), 32'd32);
        check("b2b_second_lo", bus.lo, 32'd8);
        check("b2b_second_hi", bus.hi, 32'd2);
        @(negedge clk);

        // Reset during RUN cycle 20.
        launch(32'd100, 32'd7);
        repeat (19) @(negedge clk);
        check("rst_run_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_run_busy_after", 32'(bus.busy), 32'd0);
        check("rst_run_done", 32'(bus.done), 32'd0);
        check("rst_run_lo", bus.lo, 32'd0);
        check("rst_run_hi", bus.hi, 32'd0);
        check("rst_run_dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
